// File: rtl/sumsq_acc_fsm.sv
// sumsq_acc_fsm: accumulates blocks of N non-negative fp32 squares into a
// truncating fp32 running sum, with a sticky error flag and a one-cycle
// completion pulse. Per sample: IDLE (capture) -> ALIGN -> ADD -> NORM.
module sumsq_acc_fsm #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d,
    input  logic        d_err,
    input  logic        r_i,
    output logic [31:0] sum,
    output logic        err,
    output logic        busy,
    output logic        r_o,
    output logic [7:0]  cnt
);

    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sum_q, sum_d;
    logic        err_q, err_d;
    logic        r_o_q, r_o_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fresh_q, fresh_d;

    // Captured sample; first_q marks the first sample of a new block so the
    // accumulator, err and cnt restart without disturbing the visible outputs
    // before NORM.
    logic [30:0] smp_q;
    logic        serr_q;
    logic        first_q;

    // ALIGN results: common exponent, aligned mantissas, and a bypass value
    // used when one operand is zero, the sample is errored, or sum is +inf.
    logic [7:0]  exp_q;
    logic [23:0] ma_q, mb_q;
    logic [31:0] pass_q;
    logic        byp_q;
    logic [24:0] add_q;

    // ALIGN combinational terms
    logic [31:0] acc;
    logic [7:0]  ea, eb, diff;
    logic [23:0] ma_raw, mb_raw;
    logic [7:0]  exp_a;
    logic [23:0] ma_a, mb_a;
    logic [31:0] pass_a;
    logic        byp_a;

    // NORM combinational terms
    logic [8:0]  exp_n;
    logic [22:0] frac_n;
    logic [31:0] res_n;
    logic        ovf_n;

    // Alignment: pick the larger exponent and right-shift the smaller mantissa.
    always_comb begin
        acc    = first_q ? 32'd0 : sum_q;
        ea     = acc[30:23];
        eb     = smp_q[30:23];
        ma_raw = (ea != 8'd0) ? {1'b1, acc[22:0]} : 24'd0;
        mb_raw = (eb != 8'd0) ? {1'b1, smp_q[22:0]} : 24'd0;
        exp_a  = ea;
        ma_a   = ma_raw;
        mb_a   = mb_raw;
        diff   = 8'd0;
        if (eb >= ea) begin
            exp_a = eb;
            diff  = eb - ea;
            ma_a  = (diff >= 8'd24) ? 24'd0 : (ma_raw >> diff);
        end else begin
            diff  = ea - eb;
            mb_a  = (diff >= 8'd24) ? 24'd0 : (mb_raw >> diff);
        end
        byp_a  = serr_q || (ea == 8'hFF) || (ea == 8'd0) || (eb == 8'd0);
        if (serr_q || (ea == 8'hFF) || (eb == 8'd0))
            pass_a = acc;
        else
            pass_a = {1'b0, smp_q};
    end

    // Normalisation: at most one right shift since both operands are non-negative.
    always_comb begin
        exp_n  = {1'b0, exp_q} + {8'd0, add_q[24]};
        frac_n = add_q[24] ? add_q[23:1] : add_q[22:0];
        ovf_n  = 1'b0;
        if (byp_q) begin
            res_n = pass_q;
        end else if (exp_n >= 9'd255) begin
            res_n = POS_INF;
            ovf_n = 1'b1;
        end else begin
            res_n = {1'b0, exp_n[7:0], frac_n};
        end
    end

    // Next-state and control-register updates.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        err_d   = err_q;
        r_o_d   = 1'b0;
        cnt_d   = cnt_q;
        fresh_d = fresh_q;
        case (state_q)
            IDLE: begin
                if (r_i) begin
                    state_d = ALIGN;
                    fresh_d = 1'b0;
                end
            end
            ALIGN: state_d = ADD;
            ADD:   state_d = NORM;
            NORM: begin
                sum_d = res_n;
                err_d = (first_q ? 1'b0 : err_q) | serr_q | ovf_n;
                cnt_d = (first_q ? 8'd0 : cnt_q) + 8'd1;
                state_d = (cnt_d == 8'(N)) ? DONE : IDLE;
            end
            DONE: begin
                r_o_d   = 1'b1;
                fresh_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= 32'd0;
            err_q   <= 1'b0;
            r_o_q   <= 1'b0;
            cnt_q   <= 8'd0;
            fresh_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            r_o_q   <= r_o_d;
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
        end
    end

    // Datapath registers: loaded per stage, no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && r_i) begin
            smp_q   <= d[30:0];
            serr_q  <= d_err;
            first_q <= fresh_q;
        end
        if (state_q == ALIGN) begin
            exp_q  <= exp_a;
            ma_q   <= ma_a;
            mb_q   <= mb_a;
            pass_q <= pass_a;
            byp_q  <= byp_a;
        end
        if (state_q == ADD)
            add_q <= {1'b0, ma_q} + {1'b0, mb_q};
    end

    assign sum  = sum_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);
    assign r_o  = r_o_q;
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_sumsq_acc_fsm.sv
// Bench for sumsq_acc_fsm: three instances (N=2,3,4) share one input bus;
// each scenario resets, drives one block and checks against an fp32 model.
module tb_sumsq_acc_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] d = 32'd0;
    logic        d_err = 1'b0;
    logic        r_i = 1'b0;

    logic [31:0] sum_w [3];
    logic        err_w [3];
    logic        busy_w [3];
    logic        r_o_w [3];
    logic [7:0]  cnt_w [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] smp [16];
    logic        serr [16];

    always #5 clk = ~clk;

    sumsq_acc_fsm #(.N(2)) u_n2 (.clk(clk), .rst(rst), .d(d), .d_err(d_err), .r_i(r_i),
        .sum(sum_w[0]), .err(err_w[0]), .busy(busy_w[0]), .r_o(r_o_w[0]), .cnt(cnt_w[0]));
    sumsq_acc_fsm #(.N(3)) u_n3 (.clk(clk), .rst(rst), .d(d), .d_err(d_err), .r_i(r_i),
        .sum(sum_w[1]), .err(err_w[1]), .busy(busy_w[1]), .r_o(r_o_w[1]), .cnt(cnt_w[1]));
    sumsq_acc_fsm #(.N(4)) u_n4 (.clk(clk), .rst(rst), .d(d), .d_err(d_err), .r_i(r_i),
        .sum(sum_w[2]), .err(err_w[2]), .busy(busy_w[2]), .r_o(r_o_w[2]), .cnt(cnt_w[2]));

    // Truncating fp32 add of two non-negative values, from value semantics.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, s;
        int ea, eb, e;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (eb == 0) return a;
        if (ea == 0) return {1'b0, b[30:0]};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = (ea > eb) ? ea : eb;
        ma = ma >> (e - ea);
        mb = mb >> (e - eb);
        s  = ma + mb;
        if (s >= 64'd16777216) begin
            s = s >> 1;
            e = e + 1;
        end
        if (e >= 255) return 32'h7F80_0000;
        return {1'b0, 8'(e), s[22:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; r_i = 1'b0; d_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_sample(input int idx, input logic [31:0] dv, input logic ev,
                             input logic [31:0] xs, input logic xe, input logic [7:0] xc,
                             input logic last, input string nm);
        logic xr;
        @(negedge clk);
        d = dv; d_err = ev; r_i = 1'b1;
        @(posedge clk); #1;
        r_i = 1'b0; d_err = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            xr = last && (k == 4);
            checks++;
            if (r_o_w[idx] !== xr) begin
                errors++;
                $display("FAIL %s r_o k=%0d got %b exp %b", nm, k, r_o_w[idx], xr);
            end
            if (k == 3 || (k == 4 && last)) begin
                checks++;
                if (sum_w[idx] !== xs || err_w[idx] !== xe || cnt_w[idx] !== xc) begin
                    errors++;
                    $display("FAIL %s k=%0d sum/err/cnt got %h/%b/%0d exp %h/%b/%0d",
                             nm, k, sum_w[idx], err_w[idx], cnt_w[idx], xs, xe, xc);
                end
                checks++;
                if (busy_w[idx] !== ((k == 3) && last)) begin
                    errors++;
                    $display("FAIL %s busy k=%0d got %b exp %b", nm, k, busy_w[idx], (k == 3) && last);
                end
            end
        end
    endtask

    task automatic run_block(input int idx, input int n, input string nm);
        logic [31:0] acc;
        logic        me;
        acc = 32'd0;
        me  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (serr[i]) me = 1'b1;
            else if (acc != 32'h7F80_0000) begin
                acc = m_add(acc, smp[i] & 32'h7FFF_FFFF);
                if (acc == 32'h7F80_0000) me = 1'b1;
            end
            do_sample(idx, smp[i], serr[i], acc, me, 8'(i + 1), i == n - 1, nm);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sum_w[i] !== 32'd0 || err_w[i] !== 1'b0 || busy_w[i] !== 1'b0 ||
                r_o_w[i] !== 1'b0 || cnt_w[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset inst%0d sum=%h err=%b busy=%b r_o=%b cnt=%0d exp all 0",
                         i, sum_w[i], err_w[i], busy_w[i], r_o_w[i], cnt_w[i]);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) begin smp[i] = 32'h3F80_0000; serr[i] = 1'b0; end
        run_block(2, 4, "basic");
    endtask

    task automatic test_carry();
        do_reset();
        smp[0] = 32'h3F80_0000; serr[0] = 1'b0;
        smp[1] = 32'h4000_0000; serr[1] = 1'b0;
        run_block(0, 2, "carry1");
        smp[0] = 32'h3FC0_0000; smp[1] = 32'h3FC0_0000;
        run_block(0, 2, "carry2");
    endtask

    task automatic test_align();
        do_reset();
        smp[0] = 32'h4B80_0000; serr[0] = 1'b0;
        smp[1] = 32'h3F80_0000; serr[1] = 1'b0;
        run_block(0, 2, "align");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 3; i++) begin smp[i] = 32'h7F00_0000; serr[i] = 1'b0; end
        run_block(1, 3, "overflow");
    endtask

    task automatic test_error();
        do_reset();
        smp[0] = 32'h3F80_0000; serr[0] = 1'b0;
        smp[1] = 32'h3F80_0000; serr[1] = 1'b0;
        run_block(0, 2, "err_pre");
        smp[0] = 32'h4000_0000; serr[0] = 1'b1;
        smp[1] = 32'h3F80_0000; serr[1] = 1'b0;
        run_block(0, 2, "err_prop");
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        d = 32'h4000_0000; r_i = 1'b1;
        @(posedge clk); #1;
        r_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (sum_w[2] !== 32'd0 || cnt_w[2] !== 8'd0 || busy_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid sum=%h cnt=%0d busy=%b exp 0/0/0", sum_w[2], cnt_w[2], busy_w[2]);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (r_o_w[2] !== 1'b0 || sum_w[2] !== 32'd0) begin
                errors++;
                $display("FAIL rst_mid_after k=%0d r_o=%b sum=%h exp 0/0", k, r_o_w[2], sum_w[2]);
            end
        end
        // rst and r_i on the same edge: the sample is dropped
        @(negedge clk);
        rst = 1'b1; r_i = 1'b1; d = 32'h3F80_0000;
        @(posedge clk); #1;
        rst = 1'b0; r_i = 1'b0;
        checks++;
        if (busy_w[0] !== 1'b0 || cnt_w[0] !== 8'd0) begin
            errors++;
            $display("FAIL rst_vs_ri busy=%b cnt=%0d exp 0/0", busy_w[0], cnt_w[0]);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (cnt_w[0] !== 8'd0) begin
                errors++;
                $display("FAIL rst_vs_ri_after cnt=%0d exp 0", cnt_w[0]);
            end
        end
    endtask

    task automatic test_busy_drop();
        do_reset();
        @(negedge clk);
        d = 32'h3F80_0000; r_i = 1'b1;
        @(posedge clk); #1;
        r_i = 1'b0;
        @(negedge clk);
        r_i = 1'b1; d = 32'h4000_0000;
        @(posedge clk); #1;
        r_i = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                checks++;
                if (cnt_w[2] !== 8'd1 || sum_w[2] !== 32'h3F80_0000) begin
                    errors++;
                    $display("FAIL busy_drop cnt=%0d sum=%h exp 1/3f800000", cnt_w[2], sum_w[2]);
                end
            end
            checks++;
            if (r_o_w[2] !== 1'b0) begin
                errors++;
                $display("FAIL busy_drop r_o k=%0d got 1 exp 0", k);
            end
        end
    endtask

    task automatic test_random();
        int idx, r;
        for (int b = 0; b < 10; b++) begin
            do_reset();
            idx = int'($urandom_range(0, 2));
            for (int i = 0; i < idx + 2; i++) begin
                r = int'($urandom_range(0, 9));
                smp[i] = $urandom;
                if (r == 0) smp[i][30:23] = 8'd0;
                else if (r == 1) smp[i][30:23] = 8'($urandom_range(250, 254));
                else smp[i][30:23] = 8'($urandom_range(120, 135));
                serr[i] = ($urandom_range(0, 7) == 0);
            end
            run_block(idx, idx + 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_align();
        test_overflow();
        test_error();
        test_reset_mid();
        test_busy_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/sumsq_acc_fsm.md
# sumsq_acc_fsm

Downstream consumer of the fp32 squaring stage. It accumulates a block of `N` single-precision squares into a running fp32 sum and reports the total with a one-cycle completion pulse. Its `d`, `d_err` and `r_i` inputs connect directly to the squarer's `res`, `err` and `r_o`. Together the two blocks form a sum-of-squares datapath.

## Interface

- `N`, default 4: samples per accumulation block; range 1..255.
- `clk`: input, 1 bit. Single clock. All state changes on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `d`: input, 32 bits. fp32 sample: bit 31 sign, bits 30:23 exponent, bits 22:0 mantissa.
- `d_err`: input, 1 bit. Overflow flag from the squarer, qualified by `r_i`.
- `r_i`: input, 1 bit. Sample valid. Sampled only in IDLE.
- `sum`: output, 32 bits. Accumulated fp32 sum.
- `err`: output, 1 bit. Sticky error flag for the current block.
- `busy`: output, 1 bit. High whenever `state != IDLE`.
- `r_o`: output, 1 bit. One-cycle pulse: block complete, `sum` and `err` final.
- `cnt`: output, 8 bits. Samples accepted in the current block.

## Operation

**Number format**
- Samples are squares, so the sign bit of `d` is ignored and treated as 0.
- Exponent 0 is zero. Denormals are flushed to zero.
- Rounding is truncation everywhere; there is no round-to-nearest.

**State machine:** IDLE → ALIGN → ADD → NORM → (DONE if last sample) → IDLE. The encoding is 3 bits; unused codes go to IDLE.

- **IDLE**
  - When `r_i`=1, capture `d` and `d_err`, then go to ALIGN.
  - When `r_i`=0, stay in IDLE.
  - If the previous block has completed (fresh flag set), the accumulator operand is forced to zero, `err` is cleared and `cnt` is cleared before this sample is counted.
- **ALIGN**
  - Form 24-bit mantissas with the hidden bit: hidden bit 1 if exponent ≠ 0, otherwise the whole mantissa is 0.
  - Select the larger exponent.
  - Right-shift the smaller mantissa by the exponent difference. A difference ≥ 24 makes it 0.
- **ADD:** 25-bit unsigned add of the two mantissas.
- **NORM**
  - If bit 24 of the result is set, shift right by 1 and add 1 to the exponent. No left normalisation is needed, because both operands are non-negative.
  - If either operand is zero, the result is the other operand unchanged.
  - Write `sum`. Increment `cnt`.
  - If `cnt`+1 == `N`, go to DONE; otherwise go to IDLE.
- **DONE:** set `r_o`<=1, set the fresh flag, go to IDLE.

**Error and overflow**
- If the captured `d_err`=1:
  - the sample is counted but not added;
  - `sum` is unchanged;
  - `err`<=1.
- If the normalised exponent reaches 255:
  - `sum`<=32'h7F80_0000 (+inf) and `err`<=1;
  - the remaining samples of the block are counted but not added, so `sum` stays +inf.
- `err` stays set until the first sample of the next block or `rst`.

**Input while busy:** `r_i` pulses while `busy`=1 are dropped: not counted, no effect. The squarer's result spacing is at least 6 cycles, so this never happens in normal use.

## Timing

- **Reset values:** `sum`=0, `err`=0, `busy`=0, `r_o`=0, `cnt`=0, state=IDLE, fresh flag=1.
- **Cycle timeline** (edge E0 samples `r_i`=1 in IDLE):
  - E1: ALIGN.
  - E2: ADD.
  - E3: NORM; `sum`, `err` and `cnt` update.
  - Non-last sample: IDLE from E3; `busy` low after E3; next sample accepted at E4.
  - Last sample: DONE from E3; at E4 `r_o` rises for exactly one cycle; `busy` low after E4; next sample accepted at E5.
- **Output stability:** `sum` and `err` hold their values from the `r_o` pulse until E3 of the next block's first sample.
- **`rst` in any state, including mid-add:** the next cycle shows all reset values. A partially processed sample is discarded. A pending `r_o` is cancelled.
- **`r_i` and `rst` both high on the same edge:** `rst` wins; the sample is dropped.

## Test plan

- **Basic block (N=4):** four samples of 32'h3F80_0000 (1.0), spaced 6 cycles → exactly one `r_o` pulse, `sum`=32'h4080_0000 (4.0), `err`=0, `cnt`=4. The pulse arrives 4 cycles after the fourth `r_i`.
- **Carry normalisation (N=2):** 32'h3F80_0000 then 32'h4000_0000 → `sum`=32'h4040_0000 (3.0). Then 32'h3FC0_0000 twice in the next block → `sum`=32'h4040_0000 with `err` cleared, which checks the fresh-block restart.
- **Alignment underflow (N=2):** 32'h4B80_0000 (2^24) then 32'h3F80_0000 → `sum`=32'h4B80_0000; the shift of 24 truncates to 0.
- **Overflow (N=3):** 32'h7F00_0000 three times → `sum`=32'h7F80_0000, `err`=1, `r_o` pulses once.
- **Error propagation (N=2):** 32'h4000_0000 with `d_err`=1, then 32'h3F80_0000 → `sum`=32'h3F80_0000, `err`=1.
- **Reset and busy drop:** `rst`=1 during ADD → next cycle `sum`=0, `cnt`=0, `busy`=0, and no `r_o` follows. Separately, an `r_i` pulse at E1 is ignored: `cnt` increments by only 1.
